// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, frame geometry, divisor helper.
package uart_pkg;

   // Start bit + 8 data bits + stop bit.
   localparam int unsigned FRAME_BITS = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   // Oscillator cycles per serial bit; the receive side uses the same divisor.
   function automatic int unsigned calc_div(input int unsigned osc_hz, input int unsigned baud);
      return osc_hz / baud;
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// Circular-buffer FIFO with registered full/empty/count flags.
module uart_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_c,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_fifo: DEPTH must be a power of two, 2 or more");
   end

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count_next;
   logic             do_push;
   logic             do_pop;

   // A push into a full FIFO is only legal when a pop frees the slot in the same cycle.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head_c  = mem[rd_ptr];

   // Occupancy update; simultaneous push and pop leave it unchanged.
   always_comb begin
      count_next = count;
      if (do_push && !do_pop) begin
         count_next = count + CW'(1);
      end else if (!do_push && do_pop) begin
         count_next = count - CW'(1);
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count_next;
         full  <= (count_next == CW'(DEPTH));
         empty <= (count_next == '0);
      end
   end

   // Storage needs no reset; only entries behind the write pointer are ever read.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter with input FIFO and stretched activity indicator.
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned OSCRATE   = 12_000_000,
   parameter int unsigned BAUDRATE  = 300,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned HOLD_BITS = 16
) (
   input  logic       osc,
   input  logic       rst_n,
   input  logic [7:0] data,
   input  logic       valid,
   output logic       ready,
   output logic       tx,
   output logic       busy,
   output logic       activity
);

   localparam int unsigned BIT_DIV   = calc_div(OSCRATE, BAUDRATE);
   localparam int unsigned CW        = $clog2(DEPTH) + 1;
   localparam int unsigned DATA_BITS = FRAME_BITS - 2;
   localparam int unsigned HOLD_LOAD = HOLD_BITS * BIT_DIV - 1;
   localparam int unsigned HW        = $clog2(HOLD_BITS * BIT_DIV + 1);
   localparam logic [15:0] BIT_LOAD  = 16'(BIT_DIV - 1);
   localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);

   if (BIT_DIV > 65_536 || BIT_DIV < 2) begin : g_bad_div
      $error("uart_tx: OSCRATE/BAUDRATE must lie in 2..65536");
   end

   tx_state_t     state;
   tx_state_t     state_next;
   logic [15:0]   bit_cnt;
   logic [15:0]   bit_cnt_next;
   logic [2:0]    bit_idx;
   logic [2:0]    bit_idx_next;
   logic [7:0]    shift;
   logic [7:0]    shift_next;
   logic          tx_next;
   logic          expire_c;
   logic          push_c;
   logic          pop_c;
   logic          full_next_c;
   logic          busy_next_c;
   logic [7:0]    fifo_head_c;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;
   logic [HW-1:0] hold;

   assign push_c   = valid && ready;
   assign expire_c = (bit_cnt == 16'd0);

   uart_fifo #(
      .WIDTH (8),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (osc),
      .rst_n     (rst_n),
      .push      (push_c),
      .push_data (data),
      .pop       (pop_c),
      .head_c    (fifo_head_c),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Next-cycle fullness, so ready drops on the same edge the last slot is taken.
   assign full_next_c = !pop_c &&
                        (fifo_full || (push_c && fifo_count == CW'(DEPTH - 1)));

   // Busy looks one cycle ahead so it falls on the edge the line returns to IDLE.
   assign busy_next_c = (state_next != IDLE) || !fifo_empty || push_c;

   // Frame sequencing: next state, shifter, bit timing and line level.
   always_comb begin
      state_next   = state;
      bit_cnt_next = bit_cnt;
      bit_idx_next = bit_idx;
      shift_next   = shift;
      tx_next      = tx;
      pop_c        = 1'b0;
      case (state)
         IDLE: begin
            tx_next = 1'b1;
            if (!fifo_empty) begin
               pop_c        = 1'b1;
               shift_next   = fifo_head_c;
               tx_next      = 1'b0;
               bit_cnt_next = BIT_LOAD;
               state_next   = START;
            end
         end
         START: begin
            if (expire_c) begin
               tx_next      = shift[0];
               shift_next   = {1'b0, shift[7:1]};
               bit_idx_next = 3'd0;
               bit_cnt_next = BIT_LOAD;
               state_next   = DATA;
            end else begin
               bit_cnt_next = bit_cnt - 16'd1;
            end
         end
         DATA: begin
            if (expire_c) begin
               bit_cnt_next = BIT_LOAD;
               if (bit_idx == LAST_BIT) begin
                  tx_next    = 1'b1;
                  state_next = STOP;
               end else begin
                  tx_next      = shift[0];
                  shift_next   = {1'b0, shift[7:1]};
                  bit_idx_next = bit_idx + 3'd1;
               end
            end else begin
               bit_cnt_next = bit_cnt - 16'd1;
            end
         end
         STOP: begin
            if (expire_c) begin
               if (!fifo_empty) begin
                  pop_c        = 1'b1;
                  shift_next   = fifo_head_c;
                  tx_next      = 1'b0;
                  bit_cnt_next = BIT_LOAD;
                  state_next   = START;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               bit_cnt_next = bit_cnt - 16'd1;
            end
         end
         default: begin
            state_next = IDLE;
            tx_next    = 1'b1;
         end
      endcase
   end

   // State and datapath registers; reset drops any frame in flight with the line high.
   always_ff @(posedge osc or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         bit_cnt <= '0;
         bit_idx <= '0;
         shift   <= '0;
         tx      <= 1'b1;
         ready   <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state   <= state_next;
         bit_cnt <= bit_cnt_next;
         bit_idx <= bit_idx_next;
         shift   <= shift_next;
         tx      <= tx_next;
         ready   <= !full_next_c;
         busy    <= busy_next_c;
      end
   end

   // Activity stretcher: reload while busy, then count down HOLD_BITS bit periods.
   always_ff @(posedge osc or negedge rst_n) begin
      if (!rst_n) begin
         hold     <= '0;
         activity <= 1'b0;
      end else begin
         if (busy) begin
            hold <= HW'(HOLD_LOAD);
         end else if (hold != '0) begin
            hold <= hold - HW'(1);
         end
         activity <= (hold != '0) || busy;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: a line monitor decodes frames and checks them against queued bytes.
module tb_uart_tx;

   localparam int unsigned OSCRATE   = 1600;
   localparam int unsigned BAUDRATE  = 100;
   localparam int unsigned DEPTH     = 4;
   localparam int unsigned HOLD_BITS = 2;

   localparam int BIT   = OSCRATE / BAUDRATE;
   localparam int FRAME = 10 * BIT;
   localparam int HOLD  = HOLD_BITS * BIT;

   logic       osc   = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] data  = 8'h00;
   logic       valid = 1'b0;
   logic       ready;
   logic       tx;
   logic       busy;
   logic       activity;

   uart_tx #(
      .OSCRATE   (OSCRATE),
      .BAUDRATE  (BAUDRATE),
      .DEPTH     (DEPTH),
      .HOLD_BITS (HOLD_BITS)
   ) dut (
      .osc      (osc),
      .rst_n    (rst_n),
      .data     (data),
      .valid    (valid),
      .ready    (ready),
      .tx       (tx),
      .busy     (busy),
      .activity (activity)
   );

   always #5 osc = ~osc;

   int cyc = 0;
   always @(posedge osc) cyc <= cyc + 1;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         n_frames = 0;
   int         exp_done = 0;
   logic [7:0] exp_q[$];
   int         starts[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d", name, act, want);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: bound expired at cycle %0d", name, cyc);
   endtask

   function automatic void expect_byte(input logic [7:0] b);
      exp_q.push_back(b);
      exp_done++;
   endfunction

   // Line monitor: every frame must match {stop, byte, start}, each bit exactly BIT cycles.
   initial begin : monitor
      int         s;
      bit         have;
      bit         ok;
      bit         aborted;
      int         bad_at;
      logic [9:0] fr;
      forever begin
         @(negedge osc);
         if (rst_n && tx === 1'b0) begin
            s = cyc;
            starts.push_back(s);
            have = (exp_q.size() != 0);
            fr = 10'h000;
            if (have) fr = {1'b1, exp_q.pop_front(), 1'b0};
            ok = 1'b1;
            aborted = 1'b0;
            bad_at = 0;
            for (int i = 0; i < FRAME; i++) begin
               if (i > 0) @(negedge osc);
               if (!rst_n) begin
                  aborted = 1'b1;
                  break;
               end
               if (ok && tx !== fr[i / BIT]) begin
                  ok = 1'b0;
                  bad_at = i;
               end
            end
            if (!aborted) begin
               n_frames++;
               n_checks++;
               if (!have) begin
                  n_fail++;
                  $display("FAIL unexpected_frame: frame started at cycle %0d with no byte queued", s);
               end else if (!ok) begin
                  n_fail++;
                  $display("FAIL frame_bits: byte 0x%02h, actual tx differs at frame cycle %0d, required %b",
                           fr[8:1], bad_at, fr[bad_at / BIT]);
               end
            end
         end
      end
   end

   task automatic push_byte(input logic [7:0] b, output int pc);
      int g = 0;
      @(negedge osc);
      while (ready !== 1'b1 && g < 2000) begin
         @(negedge osc);
         g++;
      end
      pc = cyc;
      if (ready !== 1'b1) begin
         timeout_fail("push_wait_ready");
      end else begin
         data  = b;
         valid = 1'b1;
         expect_byte(b);
         @(negedge osc);
         valid = 1'b0;
      end
   endtask

   task automatic wait_start(input int base, output int s);
      int g = 0;
      while (starts.size() <= base && g < 2000) begin
         @(negedge osc);
         g++;
      end
      if (starts.size() <= base) begin
         timeout_fail("frame_start");
         s = cyc;
      end else begin
         s = starts[base];
      end
   endtask

   task automatic wait_busy_low(output int t);
      int g = 0;
      do begin
         @(negedge osc);
         g++;
      end while (busy !== 1'b0 && g < 3000);
      if (busy !== 1'b0) timeout_fail("busy_fall");
      t = cyc;
   endtask

   task automatic wait_activity_low(output int t);
      int g = 0;
      do begin
         @(negedge osc);
         g++;
      end while (activity !== 1'b0 && g < 3000);
      if (activity !== 1'b0) timeout_fail("activity_fall");
      t = cyc;
   endtask

   task automatic wait_drain();
      int g = 0;
      do begin
         @(negedge osc);
         g++;
      end while ((exp_q.size() != 0 || busy !== 1'b0) && g < 8000);
      if (exp_q.size() != 0 || busy !== 1'b0) timeout_fail("drain");
   endtask

   initial begin : stim
      int         pc;
      int         s;
      int         t;
      int         t2;
      int         base;
      int         g;
      int         a6;
      int         lows;
      int         acc;
      logic [7:0] k;

      // Reset values while held low, ready only after the first clock of release.
      repeat (5) @(negedge osc);
      check("reset_tx", 32'(tx), 1);
      check("reset_busy", 32'(busy), 0);
      check("reset_activity", 32'(activity), 0);
      check("reset_ready", 32'(ready), 0);
      #3 rst_n = 1'b1;
      #1 check("ready_before_first_clock", 32'(ready), 0);
      @(negedge osc);
      check("ready_after_release", 32'(ready), 1);

      // Single byte: latency, frame length, busy and activity fall.
      base = starts.size();
      push_byte(8'hA5, pc);
      wait_start(base, s);
      check("start_latency", 32'(s - pc), 2);
      wait_busy_low(t);
      check("busy_fall_after_start", 32'(t - s), FRAME);
      wait_activity_low(t2);
      check("activity_fall_after_busy", 32'(t2 - t), HOLD);

      // Push during the hold window keeps activity high throughout.
      base = starts.size();
      push_byte(8'(($urandom)), pc);
      wait_start(base, s);
      wait_busy_low(t);
      lows = 0;
      repeat (10) begin
         @(negedge osc);
         if (activity !== 1'b1) lows++;
      end
      base = starts.size();
      push_byte(8'(($urandom)), pc);
      g = 0;
      while (starts.size() <= base && g < 100) begin
         @(negedge osc);
         g++;
         if (activity !== 1'b1) lows++;
      end
      check("activity_held_across_gap", 32'(lows), 0);
      wait_busy_low(t);
      wait_activity_low(t2);
      check("activity_fall_second", 32'(t2 - t), HOLD);

      // Burst 0x01..0x06 with valid held high.
      base = starts.size();
      k = 8'd1;
      a6 = -1;
      g = 0;
      while (k <= 8'd6 && g < 1000) begin
         @(negedge osc);
         g++;
         data  = k;
         valid = 1'b1;
         if (g == 8) begin
            check("burst_accepted_before_stall", 32'(k - 8'd1), 5);
            check("burst_ready_low_when_full", 32'(ready), 0);
         end
         if (ready === 1'b1) begin
            expect_byte(k);
            if (k == 8'd6) a6 = cyc;
            k = k + 8'd1;
         end
      end
      @(negedge osc);
      valid = 1'b0;
      if (k <= 8'd6) timeout_fail("burst_sixth_accept");
      wait_start(base, s);
      check("burst_ready_reopens_at_first_stop", 32'(a6 - s), FRAME);
      g = 0;
      while (starts.size() < base + 6 && g < 2000) begin
         @(negedge osc);
         g++;
      end
      if (starts.size() < base + 6) begin
         timeout_fail("burst_frames");
      end else begin
         check("burst_frames_contiguous", 32'(starts[base + 5] - starts[base]), 5 * FRAME);
         wait_busy_low(t);
         check("burst_busy_span", 32'(t - starts[base]), 6 * FRAME);
      end

      // Fill the FIFO, then offer 0x55 while ready is low: it must be dropped.
      acc = 0;
      g = 0;
      while (acc < 5 && g < 50) begin
         @(negedge osc);
         g++;
         data  = 8'($urandom_range(0, 127)) | 8'h80;
         valid = 1'b1;
         if (ready === 1'b1) begin
            expect_byte(data);
            acc++;
         end
      end
      @(negedge osc);
      valid = 1'b0;
      check("ignored_ready_low", 32'(ready), 0);
      check("ignored_count_before", 32'(dut.u_fifo.count), DEPTH);
      data  = 8'h55;
      valid = 1'b1;
      @(negedge osc);
      valid = 1'b0;
      check("ignored_count_after", 32'(dut.u_fifo.count), DEPTH);
      wait_drain();

      // Reset during data bit 3 of 0xFF with two bytes queued behind it.
      base = starts.size();
      push_byte(8'hFF, pc);
      push_byte(8'h81, pc);
      push_byte(8'h42, pc);
      wait_start(base, s);
      g = 0;
      while (cyc < s + 4 * BIT + 6 && g < 500) begin
         @(negedge osc);
         g++;
      end
      #3 rst_n = 1'b0;
      exp_q.delete();
      exp_done = n_frames;
      #1;
      check("midreset_tx", 32'(tx), 1);
      check("midreset_busy", 32'(busy), 0);
      check("midreset_ready", 32'(ready), 0);
      repeat (3) @(negedge osc);
      #3 rst_n = 1'b1;
      base = starts.size();
      repeat (400) @(negedge osc);
      check("no_frames_after_reset", 32'(starts.size() - base), 0);
      check("idle_busy_after_reset", 32'(busy), 0);
      push_byte(8'h3C, pc);
      wait_drain();

      // Randomized bytes with random gaps: queueing, back-to-back and idle cases.
      for (int r = 0; r < 20; r++) begin
         repeat ($urandom_range(0, 200)) @(negedge osc);
         push_byte(8'($urandom), pc);
      end
      wait_drain();
      repeat (2) @(negedge osc);
      check("frames_completed", 32'(n_frames), 32'(exp_done));
      check("scoreboard_empty", 32'(exp_q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter: the outbound counterpart to the RX clock-recovery prescaler. It accepts bytes over a valid/ready handshake and buffers them in a small FIFO. Each byte is serialized as 8N1 on `tx` at the same baud rate the receive side expects, by default 300 baud from a 12 MHz oscillator. A stretched activity flag drives the TX LED, mirroring the RX link indicator.

## Interface
- `OSCRATE`, default 12_000_000: oscillator frequency in Hz.
- `BAUDRATE`, default 300: serial bit rate.
- `DEPTH`, default 4: FIFO entries; must be a power of two, 2 or more.
- `HOLD_BITS`, default 16: number of bit periods `activity` stays high after the line goes idle.
- `osc` input, 1 bit: the single clock; all logic is on `posedge osc`.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `data` input, 8 bits: byte to send.
- `valid` input, 1 bit: `data` is offered this cycle.
- `ready` output, 1 bit: FIFO can accept a byte.
- `tx` output, 1 bit: serial line, idle high.
- `busy` output, 1 bit: a frame is in progress or the FIFO is non-empty.
- `activity` output, 1 bit: stretched `busy`, for the LED.

## Operation
- Constant `BIT_DIV = OSCRATE/BAUDRATE` (integer division); defaults give 40_000.
- Bit counter: 16 bits wide. Elaboration fails if `BIT_DIV` is above 65_536 or below 2.
- Handshake: a push happens when `valid && ready`. `ready` is the registered value of `!full`. A push while `ready` is low is ignored.
- The FIFO is a circular buffer with an occupancy count of width `$clog2(DEPTH)+1`.
  - A push and a pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo `DEPTH`.
- State machine states: IDLE, START, DATA, STOP.
- IDLE:
  - `tx` is 1.
  - If the FIFO is non-empty: pop the head into the shift register, set `tx` to 0, reload the bit counter to `BIT_DIV-1`, and go to START.
- START: when the bit counter reaches 0, shift out the LSB, set the bit index to 0, and go to DATA.
- DATA: each time the counter expires, shift out the next bit, LSB first. After bit 7 has been held for `BIT_DIV` cycles, drive `tx` to 1 and go to STOP.
- STOP:
  - On expiry with the FIFO non-empty: pop and go directly to START, with no idle gap.
  - On expiry with the FIFO empty: go to IDLE.
- Bit counter: counts down and reloads to `BIT_DIV-1` at every bit boundary.
- `busy` = (state is not IDLE) OR (FIFO is non-empty). Registered.
- Hold counter: loaded with `HOLD_BITS*BIT_DIV-1` on every cycle `busy` is 1. Otherwise it decrements to 0 and stops there.
- `activity` = (hold counter is not 0) OR `busy`. Registered.
- Reset values:
  - `tx`=1, `ready`=0 while `rst_n` is low, then 1 on the first clock after release.
  - `busy`=0, `activity`=0.
  - FIFO empty, state IDLE, all counters 0.
- Reset mid-frame: `tx` returns to 1 asynchronously. The frame and all queued bytes are discarded; there is no partial-frame completion.

## Timing
- From the push edge to the falling edge of the start bit: 2 cycles. The byte is written at edge N, the FIFO is visible as non-empty at edge N+1 (pop occurs), and `tx` is low after edge N+1.
- Each bit is held exactly `BIT_DIV` cycles. A frame is `10*BIT_DIV` cycles.
- Back-to-back frames: the start bit follows the stop bit with no gap.
- Capacity: `ready` falls one cycle after the FIFO fills. Total in flight is `DEPTH` queued bytes plus 1 in the shift register.
- A pop frees a slot, and `ready` rises on the following cycle.
- `activity` falls `HOLD_BITS*BIT_DIV` cycles after `busy` falls.

## Structure
- Shared package `uart_pkg`:
  - state encoding enum `tx_state_t`;
  - `FRAME_BITS=10`;
  - a function computing the divisor, shared with the receive side.
- One sub-module: `uart_fifo`, parameterised by `WIDTH` and `DEPTH`, providing push, pop, full, empty and count.
- The shifter, the FSM and the activity stretcher live in `uart_tx`.

## Test plan
All scenarios use `OSCRATE=1600`, `BAUDRATE=100` (`BIT_DIV=16`), `DEPTH=4`, `HOLD_BITS=2`.
- **Reset:** hold `rst_n` low for 5 cycles → `tx`=1, `busy`=0, `activity`=0, `ready`=0; `ready`=1 one cycle after release.
- **Single byte:** push 0xA5 → `tx` low 2 cycles after the push. Then 16-cycle bits 1,0,1,0,0,1,0,1, then stop bit 1. `busy` falls 160 cycles after the start bit begins.
- **Burst:** push 0x01..0x06 with `valid` held high → 5 bytes accepted. `ready` low until the first frame's stop bit expires, then 0x06 is accepted. All six frames are contiguous, 960 cycles with no idle gap.
- **Reset mid-frame:** assert `rst_n` low during data bit 3 of 0xFF with 2 bytes queued → `tx`=1 immediately. After release, no further frames; a new push of 0x3C yields one clean frame.
- **Activity stretch:** after the last stop bit, `activity` stays 1 for 32 cycles, then 0. A push arriving during the hold keeps `activity` continuously high.
- **Ignored push:** pulse `valid` with 0x55 while `ready`=0 → the byte never appears on `tx` and the FIFO count is unchanged.
